frame_capture_ctrl: RTL

- Pixel-clock sequencer in front of the 16-to-64-bit stream packing buffer.
- Arms on command, aligns to camera vsync, gates a programmed number of pixels per frame into the buffer, and keeps the 4-pixel packing phase aligned by zero-padding short or aborted frames.
- Counts frames, reports completion and overflow status to the config/CPU side, which is already synchronised to pclk.

---
 rtl/capture_pkg.sv | 25 ++
 rtl/frame_capture_ctrl_if.sv | 32 +++
 rtl/vsync_edge_det.sv | 29 ++
 rtl/frame_capture_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared types and defaults for the pclk-domain frame capture
// sequencer.
//   DEF_PIX_W / DEF_PCNT_W / DEF_FCNT_W : default pixel, pixel-count and
//                                         frame-count widths
//   PACK_RATIO                          : pixels per packed buffer word
//   PHASE_W                             : bits of pix_cnt that hold the packing phase
//   cap_state_e                         : sequencer states
package capture_pkg;

  localparam int DEF_PIX_W  = 16;
  localparam int DEF_PCNT_W = 24;
  localparam int DEF_FCNT_W = 8;

  localparam int PACK_RATIO = 4;
  localparam int PHASE_W    = $clog2(PACK_RATIO);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_VS   = 3'd1,
    CAPTURE   = 3'd2,
    PAD       = 3'd3,
    FRAME_END = 3'd4
  } cap_state_e;

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// frame_capture_ctrl_if: pixel bus between the capture sequencer and the
// 16-to-64-bit packing buffer.
//   buf_din       : pixel to buffer            (master -> slave)
//   buf_din_valid : pixel strobe               (master -> slave)
//   buf_start     : one-cycle buffer enable    (master -> slave)
//   buf_din_ready : buffer not full            (slave -> master)
interface frame_capture_ctrl_if
  import capture_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
);

  logic [PIX_W-1:0] buf_din;
  logic             buf_din_valid;
  logic             buf_start;
  logic             buf_din_ready;

  modport master (
    output buf_din,
    output buf_din_valid,
    output buf_start,
    input  buf_din_ready
  );

  modport slave (
    input  buf_din,
    input  buf_din_valid,
    input  buf_start,
    output buf_din_ready
  );

endinterface

// File: rtl/vsync_edge_det.sv
// vsync_edge_det: registers the camera vsync pin once and flags its rising
// edge. Shared by the pclk-domain camera blocks.
//   pclk, rst_n : pixel clock, async active-low reset
//   cam_vsync   : raw frame sync pin, active-high
//   vs_rise     : high for one cycle when the registered vsync goes 0 -> 1
module vsync_edge_det (
  input  logic pclk,
  input  logic rst_n,
  input  logic cam_vsync,
  output logic vs_rise
);

  logic vs_r;
  logic vs_prev_r;

  // Register the pin and keep the previous registered value for edge detection.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r      <= 1'b0;
      vs_prev_r <= 1'b0;
    end else begin
      vs_r      <= cam_vsync;
      vs_prev_r <= vs_r;
    end
  end

  assign vs_rise = vs_r & ~vs_prev_r;

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms on command, aligns to camera vsync, gates a
// programmed number of pixels per frame into the packing buffer and zero-pads
// short or aborted frames to the 4-pixel packing boundary.
// Optional build macro: CAPTURE_TESTPAT_EN adds cfg_testpat, which replaces
// cam_data by a per-frame ramp.
//   pclk, rst_n              : pixel clock, async active-low reset
//   arm, abort               : one-cycle commands
//   cfg_frames               : frames to capture (0 = continuous), latched at arm
//   cfg_frame_pixels         : pixels per frame, nonzero multiple of 4, latched at arm
//   cfg_testpat              : (CAPTURE_TESTPAT_EN only) ramp source select
//   cam_vsync/cam_href/data  : camera interface
//   buf_if                   : buffer pixel bus (master side)
//   busy, done               : not-IDLE level, programmed-count-complete pulse
//   overflow, short_frame    : sticky status, cleared by arm
//   frame_cnt                : completed frames since arm
module frame_capture_ctrl
  import capture_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int PCNT_W = DEF_PCNT_W,
  parameter int FCNT_W = DEF_FCNT_W
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [FCNT_W-1:0]    cfg_frames,
  input  logic [PCNT_W-1:0]    cfg_frame_pixels,
`ifdef CAPTURE_TESTPAT_EN
  input  logic                 cfg_testpat,
`endif
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [PIX_W-1:0]     cam_data,
  frame_capture_ctrl_if.master buf_if,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 short_frame,
  output logic [FCNT_W-1:0]    frame_cnt
);

  cap_state_e        state_r;
  cap_state_e        state_n;
  logic              vs_rise_s;
  logic [FCNT_W-1:0] frames_cfg_r;
  logic [PCNT_W-1:0] pixels_cfg_r;
  logic [PCNT_W-1:0] pix_cnt_r;
  logic [PCNT_W-1:0] pix_cnt_inc_s;
  logic [FCNT_W-1:0] frame_cnt_inc_s;
  logic              started_r;     // buf_start already issued since arm
  logic              abort_pad_r;   // PAD returns to IDLE instead of FRAME_END
  logic [PIX_W-1:0]  pix_src_s;

  logic arm_s;
  logic accept_s;
  logic pad_s;
  logic frame_start_s;
  logic frame_end_s;
  logic short_s;
  logic abort_pad_set_s;
  logic done_s;

  vsync_edge_det u_vs_det (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .cam_vsync (cam_vsync),
    .vs_rise   (vs_rise_s)
  );

  assign pix_cnt_inc_s   = pix_cnt_r + PCNT_W'(1'b1);
  assign frame_cnt_inc_s = frame_cnt + FCNT_W'(1'b1);

`ifdef CAPTURE_TESTPAT_EN
  logic             testpat_r;
  logic [PIX_W-1:0] ramp_r;

  // Ramp source: restarts at each frame start, advances per accepted pixel.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      testpat_r <= 1'b0;
      ramp_r    <= {PIX_W{1'b0}};
    end else begin
      if (arm_s) begin
        testpat_r <= cfg_testpat;
      end
      if (frame_start_s) begin
        ramp_r <= {PIX_W{1'b0}};
      end else if (accept_s) begin
        ramp_r <= ramp_r + PIX_W'(1'b1);
      end
    end
  end

  // Pixel source select.
  always_comb begin
    pix_src_s = cam_data;
    if (testpat_r) begin
      pix_src_s = ramp_r;
    end else begin
      pix_src_s = cam_data;
    end
  end
`else
  assign pix_src_s = cam_data;
`endif

  // Sequencer state register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and per-cycle control decode; abort outranks every frame event.
  always_comb begin
    state_n         = state_r;
    arm_s           = 1'b0;
    accept_s        = 1'b0;
    pad_s           = 1'b0;
    frame_start_s   = 1'b0;
    frame_end_s     = 1'b0;
    short_s         = 1'b0;
    abort_pad_set_s = 1'b0;
    done_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (arm) begin
          arm_s   = 1'b1;
          state_n = WAIT_VS;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_VS: begin
        if (abort) begin
          state_n = IDLE;
        end else if (vs_rise_s) begin
          frame_start_s = 1'b1;
          state_n       = CAPTURE;
        end else begin
          state_n = WAIT_VS;
        end
      end
      CAPTURE: begin
        if (abort) begin
          abort_pad_set_s = 1'b1;
          state_n         = PAD;
        end else if (cam_href) begin
          // The pixel is taken even on a vsync cycle; reaching the limit wins.
          accept_s = 1'b1;
          if (pix_cnt_inc_s == pixels_cfg_r) begin
            state_n = FRAME_END;
          end else if (vs_rise_s) begin
            short_s = 1'b1;
            state_n = PAD;
          end else begin
            state_n = CAPTURE;
          end
        end else if (vs_rise_s) begin
          short_s = 1'b1;
          state_n = PAD;
        end else begin
          state_n = CAPTURE;
        end
      end
      PAD: begin
        abort_pad_set_s = abort;
        if (pix_cnt_r[PHASE_W-1:0] != {PHASE_W{1'b0}}) begin
          pad_s   = 1'b1;
          state_n = PAD;
        end else if (abort || abort_pad_r) begin
          state_n = IDLE;
        end else begin
          state_n = FRAME_END;
        end
      end
      FRAME_END: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          frame_end_s = 1'b1;
          if ((frames_cfg_r != {FCNT_W{1'b0}}) && (frame_cnt_inc_s == frames_cfg_r)) begin
            done_s  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_VS;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered outputs, latched configuration and pixel/frame counters.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      buf_if.buf_din       <= {PIX_W{1'b0}};
      buf_if.buf_din_valid <= 1'b0;
      buf_if.buf_start     <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      overflow             <= 1'b0;
      short_frame          <= 1'b0;
      frame_cnt            <= {FCNT_W{1'b0}};
      frames_cfg_r         <= {FCNT_W{1'b0}};
      pixels_cfg_r         <= {PCNT_W{1'b0}};
      pix_cnt_r            <= {PCNT_W{1'b0}};
      started_r            <= 1'b0;
      abort_pad_r          <= 1'b0;
    end else begin
      buf_if.buf_din_valid <= accept_s | pad_s;
      buf_if.buf_din       <= accept_s ? pix_src_s : {PIX_W{1'b0}};
      buf_if.buf_start     <= frame_start_s & ~started_r;
      busy                 <= (state_n != IDLE);
      done                 <= done_s;
      if (arm_s) begin
        frames_cfg_r <= cfg_frames;
        pixels_cfg_r <= cfg_frame_pixels;
        frame_cnt    <= {FCNT_W{1'b0}};
        overflow     <= 1'b0;
        short_frame  <= 1'b0;
        started_r    <= 1'b0;
        abort_pad_r  <= 1'b0;
      end else begin
        // A stalled strobe is still counted so the packing phase stays intact.
        overflow    <= overflow | (buf_if.buf_din_valid & ~buf_if.buf_din_ready);
        short_frame <= short_frame | short_s;
        started_r   <= started_r | frame_start_s;
        abort_pad_r <= abort_pad_r | abort_pad_set_s;
        if (frame_end_s) begin
          frame_cnt <= frame_cnt_inc_s;
        end
      end
      if (frame_start_s) begin
        pix_cnt_r <= {PCNT_W{1'b0}};
      end else if (accept_s || pad_s) begin
        pix_cnt_r <= pix_cnt_inc_s;
      end
    end
  end

endmodule
